doodle_physics_fsm: RTL and testbench
=====================================

Name: doodle_physics_fsm

Overview:
Parametrised successor to the single-doodle jump state machine. It sequences the I → UP → DOWN → DONE jump cycle and owns the jump-height counter, fall timer, screen scroll offset, score and best score. It resolves landings against a runtime-loaded table of NUM_PLAT platforms instead of hard-coded coordinates. It sits between the input/tick logic and the VGA renderer, which consumes scroll, score and state.

Parameters:
NUM_PLAT, 12, number of platform slots checked for landing
COORD_W, 16, width of coordinates, scroll, score and timers (two's complement for platform y)
JUMP_HEIGHT, 160, pixels climbed in UP before switching to DOWN
DEATH_FALL, 530, accumulated fall pixels that end the game
SCROLL_LINE, 275, screen y at or above which UP scrolls the world (V_MIDDLE incl. 35 offset)
DOODLE_R, 13, doodle half-size (centre to edge)
PLAT_RW, 32, platform half-width
PLAT_RH, 7, platform half-height
SPEED_W, 4, width of vert_speed

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Start  in  1  leave I and begin first jump
Ack  in  1  acknowledge game over; DONE → I
tick  in  1  movement strobe (one per frame); all motion and transitions except Start/Ack occur only when tick=1
vert_speed  in  SPEED_W  pixels moved per tick
doodle_x  in  COORD_W  doodle centre x, screen coordinates (unsigned)
doodle_y  in  COORD_W  doodle centre y, screen coordinates (unsigned)
plat_x_flat  in  NUM_PLAT*COORD_W  platform centre x; slot i at bits [i*COORD_W +: COORD_W]
plat_y_flat  in  NUM_PLAT*COORD_W  platform centre y, signed world coordinates
plat_valid  in  NUM_PLAT  slot enable
q_I, q_Up, q_Down, q_Done  out  1 each  one-hot state
is_in_middle  out  1  UP and scrolling on the last tick
scroll  out  COORD_W  world scroll offset; screen_y = world_y + scroll
score  out  COORD_W  current score
best_score  out  COORD_W  highest score since Reset
land_pulse  out  1  one-cycle pulse on a landing
hit_index  out  clog2(NUM_PLAT)  slot of the most recent landing

Behaviour:
- Reset (async): state=I; scroll, score, best_score, up_count, fall_time, hit_index = 0; is_in_middle=0; land_pulse=0.
- All outputs are registered. A decision made in cycle t is visible in cycle t+1.
- I:
  - Start=1 (tick not needed) → UP; clear up_count, fall_time, scroll, score.
- UP, on tick:
  - up_count += vert_speed; fall_time = 0.
  - If up_count + vert_speed >= JUMP_HEIGHT → DOWN.
  - If doodle_y <= SCROLL_LINE: scroll += vert_speed, score += vert_speed (score saturates at all-ones), is_in_middle=1; otherwise is_in_middle=0.
- DOWN, on tick:
  - fall_time += vert_speed (saturating); is_in_middle=0.
  - Priority 1: fall_time + vert_speed >= DEATH_FALL → DONE; also best_score = max(best_score, score).
  - Priority 2: any hit → UP; up_count=0; land_pulse=1; hit_index = lowest hit slot.
  - Otherwise stay in DOWN.
- Hit on slot i (all four must hold; signed COORD_W+2-bit arithmetic, no wrap):
  - plat_valid[i];
  - doodle_x + DOODLE_R >= px − PLAT_RW;
  - doodle_x − DOODLE_R <= px + PLAT_RW;
  - py + scroll − PLAT_RH <= doodle_y + DOODLE_R <= py + scroll + PLAT_RH.
  - Negative py (platforms above the screen) is legal.
- DONE:
  - Outputs hold. Ack=1 → I (scroll and score hold until the next Start).
  - Start while in DONE is ignored.
- Boundary cases:
  - Ticks in I/DONE have no effect.
  - vert_speed=0 is legal: counters hold, but hit detection still runs.
  - Start and tick in the same cycle: only the I→UP transition occurs.
  - Reset mid-jump returns immediately to I; best_score is lost.
  - Illegal state → I on the next clock.

Decomposition:
- Package doodle_pkg: state encodings (I=0001, UP=0010, DOWN=0100, DONE=1000), default geometry constants (DOODLE_R, PLAT_RW, PLAT_RH, SCROLL_LINE) shared with the renderer.
- Sub-module plat_hit_detect: purely combinational, parametrised by NUM_PLAT. Outputs the hit flag and the lowest-index hit (priority encoder). The FSM instantiates it once.

Test Plan:
1. Reset, Start, vert_speed=4, doodle_y=400, 40 ticks → q_Down on the cycle after tick 40; scroll=0, score=0.
2. UP with doodle_y=200, vert_speed=5, 10 ticks → scroll=50, score=50, is_in_middle=1; then doodle_y=300 on one tick → is_in_middle=0, scroll still 50.
3. DOWN, slot 3 = (288, 208), valid, scroll=0, doodle=(280, 195), tick → land_pulse for one cycle, hit_index=3, q_Up; same stimulus with slot 5 also hitting → hit_index=3.
4. DOWN with no platforms valid, vert_speed=10 → q_Done after the 53rd tick; best_score updated to score; Ack → q_I; Start → score cleared, best_score retained.
5. Slot 0 y=−100, scroll=310, doodle_y=197 (bottom 210), DOWN tick → hit. Same with scroll=0 → no hit.
6. Reset asserted mid-DOWN asynchronously → q_I and all counters 0 in the same cycle; ticks in I leave everything 0.

Source files
------------

// File: rtl/doodle_pkg.sv
// Shared state encodings and default geometry for the doodle jump core.
// Imported by the physics FSM, the hit detector and the VGA renderer.
package doodle_pkg;

    // One-hot jump states; bit order matches {q_Done, q_Down, q_Up, q_I}
    typedef enum logic [3:0] {
        ST_I    = 4'b0001,
        ST_UP   = 4'b0010,
        ST_DOWN = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

    // Default geometry in pixels
    localparam int DEF_DOODLE_R    = 13;
    localparam int DEF_PLAT_RW     = 32;
    localparam int DEF_PLAT_RH     = 7;
    localparam int DEF_SCROLL_LINE = 275;

endpackage

// File: rtl/plat_hit_detect.sv
// Combinational landing check of the doodle against NUM_PLAT platforms.
// Ports: doodle_x/doodle_y (screen), scroll, plat_x_flat/plat_y_flat (world),
//        plat_valid in; hit flag and lowest hit slot index out.
module plat_hit_detect #(
    parameter int NUM_PLAT = 12,
    parameter int COORD_W  = 16,
    parameter int DOODLE_R = 13,
    parameter int PLAT_RW  = 32,
    parameter int PLAT_RH  = 7,
    parameter int IDX_W    = 4
) (
    input  logic [COORD_W-1:0]          doodle_x,
    input  logic [COORD_W-1:0]          doodle_y,
    input  logic [COORD_W-1:0]          scroll,
    input  logic [NUM_PLAT*COORD_W-1:0] plat_x_flat,
    input  logic [NUM_PLAT*COORD_W-1:0] plat_y_flat,
    input  logic [NUM_PLAT-1:0]         plat_valid,
    output logic                        hit,
    output logic [IDX_W-1:0]            hit_idx
);

    // Two guard bits keep unsigned screen values, signed world y and the
    // added scroll from wrapping in any of the comparisons.
    localparam int W = COORD_W + 2;

    localparam logic signed [W-1:0] R  = W'(DOODLE_R);
    localparam logic signed [W-1:0] RW = W'(PLAT_RW);
    localparam logic signed [W-1:0] RH = W'(PLAT_RH);

    logic signed [W-1:0] dx_lo;
    logic signed [W-1:0] dx_hi;
    logic signed [W-1:0] dy_bot;
    logic signed [W-1:0] sc;
    logic [NUM_PLAT-1:0] slot_hit;

    assign dx_hi  = $signed({2'b00, doodle_x}) + R;
    assign dx_lo  = $signed({2'b00, doodle_x}) - R;
    assign dy_bot = $signed({2'b00, doodle_y}) + R;
    assign sc     = $signed({2'b00, scroll});

    for (genvar i = 0; i < NUM_PLAT; i++) begin : g_slot
        logic [COORD_W-1:0] px_raw;
        logic [COORD_W-1:0] py_raw;
        logic signed [W-1:0] px;
        logic signed [W-1:0] py;

        assign px_raw = plat_x_flat[i*COORD_W +: COORD_W];
        assign py_raw = plat_y_flat[i*COORD_W +: COORD_W];
        assign px = $signed({2'b00, px_raw});
        // Platform y is world-space and may be negative; shift to screen.
        assign py = $signed({{2{py_raw[COORD_W-1]}}, py_raw}) + sc;

        assign slot_hit[i] = plat_valid[i]
                          && (dx_hi >= px - RW)
                          && (dx_lo <= px + RW)
                          && (dy_bot >= py - RH)
                          && (dy_bot <= py + RH);
    end

    // Scan downward so the lowest-index hit is the one left standing
    always_comb begin
        hit     = |slot_hit;
        hit_idx = '0;
        for (int i = NUM_PLAT - 1; i >= 0; i--) begin
            if (slot_hit[i]) hit_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/doodle_physics_fsm.sv
// Jump sequencer I -> UP -> DOWN -> DONE with scroll, score and landing.
// Ports: Clk, Reset, Start, Ack, tick, vert_speed, doodle pos, platform table
//        in; one-hot state, is_in_middle, scroll, scores, land info out.
module doodle_physics_fsm
    import doodle_pkg::*;
#(
    parameter int NUM_PLAT    = 12,
    parameter int COORD_W     = 16,
    parameter int JUMP_HEIGHT = 160,
    parameter int DEATH_FALL  = 530,
    parameter int SCROLL_LINE = DEF_SCROLL_LINE,
    parameter int DOODLE_R    = DEF_DOODLE_R,
    parameter int PLAT_RW     = DEF_PLAT_RW,
    parameter int PLAT_RH     = DEF_PLAT_RH,
    parameter int SPEED_W     = 4,
    localparam int IDX_W      = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Start,
    input  logic                        Ack,
    input  logic                        tick,
    input  logic [SPEED_W-1:0]          vert_speed,
    input  logic [COORD_W-1:0]          doodle_x,
    input  logic [COORD_W-1:0]          doodle_y,
    input  logic [NUM_PLAT*COORD_W-1:0] plat_x_flat,
    input  logic [NUM_PLAT*COORD_W-1:0] plat_y_flat,
    input  logic [NUM_PLAT-1:0]         plat_valid,
    output logic                        q_I,
    output logic                        q_Up,
    output logic                        q_Down,
    output logic                        q_Done,
    output logic                        is_in_middle,
    output logic [COORD_W-1:0]          scroll,
    output logic [COORD_W-1:0]          score,
    output logic [COORD_W-1:0]          best_score,
    output logic                        land_pulse,
    output logic [IDX_W-1:0]            hit_index
);

    state_t             state;
    logic [COORD_W-1:0] up_count;
    logic [COORD_W-1:0] fall_time;

    logic               hit;
    logic [IDX_W-1:0]   hit_idx;

    // One spare bit on each sum so threshold tests never wrap
    logic [COORD_W:0]   spd;
    logic [COORD_W:0]   up_sum;
    logic [COORD_W:0]   fall_sum;
    logic [COORD_W:0]   score_sum;
    logic [COORD_W-1:0] fall_sat;
    logic [COORD_W-1:0] score_sat;

    assign spd       = (COORD_W+1)'(vert_speed);
    assign up_sum    = {1'b0, up_count} + spd;
    assign fall_sum  = {1'b0, fall_time} + spd;
    assign score_sum = {1'b0, score} + spd;
    assign fall_sat  = fall_sum[COORD_W] ? '1 : fall_sum[COORD_W-1:0];
    assign score_sat = score_sum[COORD_W] ? '1 : score_sum[COORD_W-1:0];

    assign {q_Done, q_Down, q_Up, q_I} = state;

    plat_hit_detect #(
        .NUM_PLAT (NUM_PLAT),
        .COORD_W  (COORD_W),
        .DOODLE_R (DOODLE_R),
        .PLAT_RW  (PLAT_RW),
        .PLAT_RH  (PLAT_RH),
        .IDX_W    (IDX_W)
    ) u_hit (
        .doodle_x    (doodle_x),
        .doodle_y    (doodle_y),
        .scroll      (scroll),
        .plat_x_flat (plat_x_flat),
        .plat_y_flat (plat_y_flat),
        .plat_valid  (plat_valid),
        .hit         (hit),
        .hit_idx     (hit_idx)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= ST_I;
            up_count     <= '0;
            fall_time    <= '0;
            scroll       <= '0;
            score        <= '0;
            best_score   <= '0;
            is_in_middle <= 1'b0;
            land_pulse   <= 1'b0;
            hit_index    <= '0;
        end else begin
            land_pulse <= 1'b0;
            case (state)
                ST_I: begin
                    if (Start) begin
                        state     <= ST_UP;
                        up_count  <= '0;
                        fall_time <= '0;
                        scroll    <= '0;
                        score     <= '0;
                    end
                end
                ST_UP: begin
                    if (tick) begin
                        up_count  <= up_sum[COORD_W-1:0];
                        fall_time <= '0;
                        if (up_sum >= (COORD_W+1)'(JUMP_HEIGHT)) state <= ST_DOWN;
                        if (doodle_y <= COORD_W'(SCROLL_LINE)) begin
                            scroll       <= scroll + spd[COORD_W-1:0];
                            score        <= score_sat;
                            is_in_middle <= 1'b1;
                        end else begin
                            is_in_middle <= 1'b0;
                        end
                    end
                end
                ST_DOWN: begin
                    if (tick) begin
                        fall_time    <= fall_sat;
                        is_in_middle <= 1'b0;
                        // Death outranks a landing on the same tick
                        if (fall_sum >= (COORD_W+1)'(DEATH_FALL)) begin
                            state <= ST_DONE;
                            if (score > best_score) best_score <= score;
                        end else if (hit) begin
                            state      <= ST_UP;
                            up_count   <= '0;
                            land_pulse <= 1'b1;
                            hit_index  <= hit_idx;
                        end
                    end
                end
                ST_DONE: begin
                    if (Ack) state <= ST_I;
                end
                default: state <= ST_I;
            endcase
        end
    end

endmodule

// File: tb/tb_doodle_physics_fsm.sv
// Scoreboard bench for doodle_physics_fsm: directed jump/land/death vectors.
// Expectations are queued by the stimulus and checked by a negedge monitor.
module tb_doodle_physics_fsm;

    localparam int NP = 12;
    localparam int CW = 16;
    localparam int IW = 4;

    localparam int F_ST   = 0;
    localparam int F_SCR  = 1;
    localparam int F_SCO  = 2;
    localparam int F_BEST = 3;
    localparam int F_MID  = 4;
    localparam int F_HIX  = 5;
    localparam int F_LAND = 6;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start;
    logic             Ack;
    logic             tick;
    logic [3:0]       vert_speed;
    logic [CW-1:0]    doodle_x;
    logic [CW-1:0]    doodle_y;
    logic [NP*CW-1:0] plat_x_flat;
    logic [NP*CW-1:0] plat_y_flat;
    logic [NP-1:0]    plat_valid;
    logic             q_I, q_Up, q_Down, q_Done;
    logic             is_in_middle;
    logic [CW-1:0]    scroll;
    logic [CW-1:0]    score;
    logic [CW-1:0]    best_score;
    logic             land_pulse;
    logic [IW-1:0]    hit_index;

    logic [CW-1:0]    px [NP];
    logic [CW-1:0]    py [NP];

    typedef struct {
        string nm;
        int    f;
        int    v;
    } exp_t;

    exp_t exp_q[$];
    int   land_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    always_comb begin
        plat_x_flat = '0;
        plat_y_flat = '0;
        for (int i = 0; i < NP; i++) begin
            plat_x_flat[i*CW +: CW] = px[i];
            plat_y_flat[i*CW +: CW] = py[i];
        end
    end

    doodle_physics_fsm dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Ack          (Ack),
        .tick         (tick),
        .vert_speed   (vert_speed),
        .doodle_x     (doodle_x),
        .doodle_y     (doodle_y),
        .plat_x_flat  (plat_x_flat),
        .plat_y_flat  (plat_y_flat),
        .plat_valid   (plat_valid),
        .q_I          (q_I),
        .q_Up         (q_Up),
        .q_Down       (q_Down),
        .q_Done       (q_Done),
        .is_in_middle (is_in_middle),
        .scroll       (scroll),
        .score        (score),
        .best_score   (best_score),
        .land_pulse   (land_pulse),
        .hit_index    (hit_index)
    );

    function automatic logic [31:0] get(int f);
        case (f)
            F_ST:   return 32'({q_Done, q_Down, q_Up, q_I});
            F_SCR:  return 32'(scroll);
            F_SCO:  return 32'(score);
            F_BEST: return 32'(best_score);
            F_MID:  return 32'(is_in_middle);
            F_HIX:  return 32'(hit_index);
            default: return 32'(land_pulse);
        endcase
    endfunction

    // Monitor: drains queued expectations and checks every landing pulse
    always @(negedge Clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = exp_q.pop_front();
            act = get(e.f);
            checks++;
            if (act !== 32'(e.v)) begin
                failures++;
                $display("FAIL %s actual=%0d expected=%0d", e.nm, act, e.v);
            end
        end
        if (land_pulse === 1'b1) begin
            checks++;
            if (land_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_land actual=%0d expected=none", hit_index);
            end else begin
                int want;
                want = land_q.pop_front();
                if (32'(hit_index) !== 32'(want)) begin
                    failures++;
                    $display("FAIL land_index actual=%0d expected=%0d", hit_index, want);
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick_n(int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic ex(string n, int f, int v);
        exp_t e;
        e.nm = n;
        e.f  = f;
        e.v  = v;
        exp_q.push_back(e);
    endtask

    task automatic core(string n, int st, int scr, int sco);
        ex({n, ".state"}, F_ST, st);
        ex({n, ".scroll"}, F_SCR, scr);
        ex({n, ".score"}, F_SCO, sco);
    endtask

    task automatic clear_plats();
        plat_valid = '0;
        for (int i = 0; i < NP; i++) begin
            px[i] = '0;
            py[i] = '0;
        end
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Ack = 1'b0;
        tick = 1'b0;
        vert_speed = '0;
        doodle_x = 16'd280;
        doodle_y = 16'd400;
        clear_plats();
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Reset state
        core("reset", 1, 0, 0);
        ex("reset.best", F_BEST, 0);
        ex("reset.hix", F_HIX, 0);
        ex("reset.mid", F_MID, 0);
        ex("reset.land", F_LAND, 0);
        step();

        // Ticks in I do nothing
        vert_speed = 4'd10;
        tick_n(3);
        core("idle_tick", 1, 0, 0);

        // Start with tick: only the transition happens
        Start = 1'b1;
        tick = 1'b1;
        vert_speed = 4'd4;
        step();
        Start = 1'b0;
        tick = 1'b0;
        core("start", 2, 0, 0);

        // Climb 160 px at 4/tick, no scrolling at y=400
        tick_n(39);
        ex("up39.state", F_ST, 2);
        tick_n(1);
        core("up40", 4, 0, 0);
        ex("up40.mid", F_MID, 0);

        // Landing on slot 3 with zero speed
        px[3] = 16'd288;
        py[3] = 16'd208;
        plat_valid[3] = 1'b1;
        doodle_y = 16'd195;
        vert_speed = 4'd0;
        land_q.push_back(3);
        tick_n(1);
        core("land3", 2, 0, 0);
        ex("land3.pulse", F_LAND, 1);
        ex("land3.hix", F_HIX, 3);
        step();
        ex("land3.once", F_LAND, 0);
        plat_valid = '0;

        // Scroll while above the middle line
        doodle_y = 16'd200;
        vert_speed = 4'd5;
        tick_n(10);
        core("mid", 2, 50, 50);
        ex("mid.flag", F_MID, 1);
        doodle_y = 16'd300;
        tick_n(1);
        core("below", 2, 50, 50);
        ex("below.flag", F_MID, 0);
        doodle_y = 16'd400;
        tick_n(20);
        ex("up155.state", F_ST, 2);
        tick_n(1);
        core("down2", 4, 50, 50);

        // Two slots hit: lowest index wins
        px[3] = 16'd288;
        py[3] = 16'd158;
        px[5] = 16'd288;
        py[5] = 16'd158;
        plat_valid[3] = 1'b1;
        plat_valid[5] = 1'b1;
        doodle_y = 16'd195;
        vert_speed = 4'd0;
        land_q.push_back(3);
        tick_n(1);
        core("land35", 2, 50, 50);
        ex("land35.hix", F_HIX, 3);
        plat_valid = '0;

        // Full scrolling jump then land on slot 1
        doodle_y = 16'd200;
        vert_speed = 4'd10;
        tick_n(16);
        core("j3", 4, 210, 210);
        px[1] = 16'd288;
        py[1] = 16'hFFFE;
        plat_valid[1] = 1'b1;
        doodle_y = 16'd195;
        vert_speed = 4'd0;
        land_q.push_back(1);
        tick_n(1);
        core("land1", 2, 210, 210);
        plat_valid = '0;

        // Partial scroll to 310, finish climb low
        doodle_y = 16'd200;
        vert_speed = 4'd10;
        tick_n(10);
        core("j4", 2, 310, 310);
        doodle_y = 16'd400;
        vert_speed = 4'd15;
        tick_n(4);
        core("j4down", 4, 310, 310);

        // Negative world y reaches screen through scroll
        px[0] = 16'd288;
        py[0] = 16'hFF9C;
        plat_valid[0] = 1'b1;
        doodle_y = 16'd197;
        vert_speed = 4'd0;
        land_q.push_back(0);
        tick_n(1);
        core("neg_y", 2, 310, 310);
        ex("neg_y.hix", F_HIX, 0);
        plat_valid = '0;

        // Fall to death at 10/tick
        doodle_y = 16'd400;
        vert_speed = 4'd10;
        tick_n(16);
        ex("fall.entry", F_ST, 4);
        tick_n(52);
        ex("fall52.state", F_ST, 4);
        tick_n(1);
        core("dead", 8, 310, 310);
        ex("dead.best", F_BEST, 310);
        ex("dead.mid", F_MID, 0);

        // DONE ignores Start and ticks
        Start = 1'b1;
        step();
        Start = 1'b0;
        ex("done_start.state", F_ST, 8);
        tick_n(2);
        core("done_tick", 8, 310, 310);

        Ack = 1'b1;
        step();
        Ack = 1'b0;
        core("ack", 1, 310, 310);
        Start = 1'b1;
        step();
        Start = 1'b0;
        core("restart", 2, 0, 0);
        ex("restart.best", F_BEST, 310);

        // Same negative-y platform without scroll misses
        tick_n(16);
        core("g2down", 4, 0, 0);
        px[0] = 16'd288;
        py[0] = 16'hFF9C;
        plat_valid[0] = 1'b1;
        doodle_y = 16'd197;
        vert_speed = 4'd0;
        tick_n(1);
        ex("neg_y_miss.state", F_ST, 4);
        plat_valid = '0;

        // Horizontal edge: right overlap limit
        px[3] = 16'd288;
        py[3] = 16'd208;
        plat_valid[3] = 1'b1;
        doodle_y = 16'd195;
        doodle_x = 16'd334;
        tick_n(1);
        ex("x334.state", F_ST, 4);
        doodle_x = 16'd333;
        land_q.push_back(3);
        tick_n(1);
        ex("x333.state", F_ST, 2);
        plat_valid = '0;
        doodle_x = 16'd280;

        // Async reset mid-DOWN
        doodle_y = 16'd400;
        vert_speed = 4'd10;
        tick_n(16);
        tick_n(5);
        ex("pre_rst.state", F_ST, 4);
        ex("pre_rst.best", F_BEST, 310);
        step();
        Reset = 1'b1;
        core("async_rst", 1, 0, 0);
        ex("async_rst.best", F_BEST, 0);
        ex("async_rst.hix", F_HIX, 0);
        step();
        Reset = 1'b0;
        tick_n(3);
        core("post_rst", 1, 0, 0);
        ex("post_rst.best", F_BEST, 0);

        step();
        step();
        checks++;
        if (land_q.size() != 0) begin
            failures++;
            $display("FAIL missing_land actual=0 expected=%0d", land_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
